// File: rtl/tmr_sequencer_pkg.sv
// Shared constants for the timer sequencer: state encodings and the default watchdog limit.
package tmr_sequencer_pkg;

    localparam int          SEQ_STEP_W_C = 8;
    localparam int          SEQ_WDOG_W_C = 22;
    localparam int unsigned SEQ_WDOG_C   = 32'h003F_FFFF;

    typedef enum logic [1:0] {
        SEQ_IDLE_S  = 2'd0,
        SEQ_ARM_S   = 2'd1,
        SEQ_WAIT_S  = 2'd2,
        SEQ_DRAIN_S = 2'd3
    } seq_state_e;

endpackage

// File: rtl/tmr_sequencer.sv
// Initiator side of the timer handshake: runs STEPS back-to-back one-shot periods,
// reports each period and the final completion, and guards the timer with a watchdog.
module tmr_sequencer
    import tmr_sequencer_pkg::*;
#(
    parameter int          STEP_W   = SEQ_STEP_W_C,
    parameter int          WDOG_W   = SEQ_WDOG_W_C,
    parameter int unsigned WDOG_MAX = SEQ_WDOG_C
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              GO,
    input  logic [STEP_W-1:0] STEPS,
    input  logic              ABORT,
    input  logic              PULSE,
    output logic              START_TMR,
    output logic              BUSY,
    output logic              STEP,
    output logic [STEP_W-1:0] STEP_IDX,
    output logic              DONE,
    output logic              ERR
);

    localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_MAX);

    seq_state_e        state;
    logic [STEP_W-1:0] steps_q;
    logic [WDOG_W-1:0] wdog;
    logic [WDOG_W-1:0] wdog_inc;
    logic              wdog_exp;
    logic [STEP_W-1:0] idx_inc;
    logic              last_step;

    // Expiry is judged on the value the counter is about to take, so the error
    // lands WDOG_MAX+1 cycles after the timer start.
    always_comb begin
        wdog_inc  = (wdog == WDOG_LIM) ? wdog : wdog + WDOG_W'(1);
        wdog_exp  = (wdog_inc == WDOG_LIM);
        idx_inc   = STEP_IDX + STEP_W'(1);
        last_step = (idx_inc == steps_q);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= SEQ_IDLE_S;
            START_TMR <= 1'b0;
            BUSY      <= 1'b0;
            STEP      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            STEP_IDX  <= '0;
            steps_q   <= '0;
            wdog      <= '0;
        end else begin
            START_TMR <= 1'b0;
            STEP      <= 1'b0;
            DONE      <= 1'b0;
            case (state)
                SEQ_IDLE_S: begin
                    if (GO) begin
                        ERR <= 1'b0;
                        if (STEPS != '0) begin
                            steps_q   <= STEPS;
                            STEP_IDX  <= '0;
                            START_TMR <= 1'b1;
                            BUSY      <= 1'b1;
                            state     <= SEQ_ARM_S;
                        end else begin
                            DONE <= 1'b1;
                        end
                    end
                end
                SEQ_ARM_S: begin
                    wdog  <= '0;
                    state <= SEQ_WAIT_S;
                end
                SEQ_WAIT_S: begin
                    wdog <= wdog_inc;
                    if (PULSE) begin
                        STEP     <= 1'b1;
                        STEP_IDX <= idx_inc;
                        if (last_step) begin
                            DONE  <= 1'b1;
                            BUSY  <= 1'b0;
                            state <= SEQ_IDLE_S;
                        end else if (ABORT) begin
                            BUSY  <= 1'b0;
                            state <= SEQ_IDLE_S;
                        end else begin
                            START_TMR <= 1'b1;
                            state     <= SEQ_ARM_S;
                        end
                    end else if (ABORT) begin
                        state <= SEQ_DRAIN_S;
                    end else if (wdog_exp) begin
                        ERR   <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= SEQ_IDLE_S;
                    end
                end
                // The timer cannot be cancelled, so its pending pulse is swallowed here.
                SEQ_DRAIN_S: begin
                    wdog <= wdog_inc;
                    if (PULSE) begin
                        BUSY  <= 1'b0;
                        state <= SEQ_IDLE_S;
                    end else if (wdog_exp) begin
                        ERR   <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= SEQ_IDLE_S;
                    end
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= SEQ_IDLE_S;
                end
            endcase
        end
    end

endmodule

// File: doc/tmr_sequencer.md
# tmr_sequencer

Initiator side of the timer handshake: drives START_TMR into the one-shot timer and consumes its PULSE. It runs a requested number of back-to-back timer periods and reports each completed period and the final completion. A watchdog flags a timer that never answers. ABORT is supported; because the timer cannot be cancelled, the block drains the outstanding PULSE so that a stale pulse never reaches the next run.

## Interface
- STEP_W, 8, width of step count and step index
- WDOG_W, 22, watchdog counter width
- WDOG_MAX, 2^22-1, watchdog limit in cycles (must exceed timer period + 2)
- CLK  in  1  clock, all flops posedge
- RST_N  in  1  asynchronous active-low reset
- GO  in  1  start request, sampled only in IDLE
- STEPS  in  STEP_W  number of timer periods, sampled with GO
- ABORT  in  1  cancel request, level, sampled in WAIT
- PULSE  in  1  one-cycle completion pulse from timer
- START_TMR  out  1  one-cycle timer start, registered
- BUSY  out  1  high in any state other than IDLE
- STEP  out  1  one-cycle pulse per completed period
- STEP_IDX  out  STEP_W  count of completed periods in current run
- DONE  out  1  one-cycle pulse when all STEPS periods complete
- ERR  out  1  sticky watchdog error, cleared by next accepted GO

## Operation
- States (shared encodings): SEQ_IDLE_S, SEQ_ARM_S, SEQ_WAIT_S, SEQ_DRAIN_S; unused encodings go to IDLE.
- IDLE:
  - GO with STEPS!=0: latch steps_q<=STEPS, STEP_IDX<=0, ERR<=0, then go to ARM.
  - GO with STEPS==0: DONE pulse next cycle, ERR<=0, no START_TMR, stay IDLE.
- ARM: START_TMR high for exactly this cycle; wdog<=0; then go to WAIT unconditionally.
- WAIT: wdog increments each cycle. Priority is PULSE > ABORT > watchdog.
  - PULSE: STEP pulse and STEP_IDX+1. If the new index == steps_q, DONE pulse and go to IDLE; otherwise go to ARM.
  - PULSE with ABORT in the same cycle: STEP counted and STEP_IDX updated. Go to IDLE with no DONE, or with DONE if this was the last step.
  - ABORT without PULSE: go to DRAIN.
  - wdog==WDOG_MAX without PULSE: ERR<=1, go to IDLE, no DONE.
- DRAIN: wdog keeps counting without reset. PULSE: go to IDLE with no STEP and no STEP_IDX change. Watchdog expiry: ERR<=1, go to IDLE. ABORT is ignored.
- GO outside IDLE is ignored and not queued.
- STEP_IDX holds its value in IDLE until the next accepted GO.
- PULSE outside WAIT/DRAIN is ignored.
- Arithmetic: STEP_IDX never wraps, since the run ends when STEP_IDX==steps_q (max 2^STEP_W-1). wdog saturates at WDOG_MAX.

## Timing
- Reset (async assert, sync deassert by system) sets: state IDLE, START_TMR=0, BUSY=0, STEP=0, DONE=0, ERR=0, STEP_IDX=0, steps_q=0, wdog=0.
- Reset mid-run: all outputs return immediately to reset values. The external timer, if mid-count, still emits its PULSE, which is ignored in IDLE.
- All outputs are registered; STEP, DONE and START_TMR are pulses exactly one cycle wide.
- GO sampled at edge e: BUSY and START_TMR high in cycle e+1.
- For a timer whose PULSE appears L cycles after START_TMR is sampled:
  - period per step is L+1 cycles (ARM to ARM);
  - STEP pulses in the cycle after PULSE;
  - DONE coincides with the final STEP;
  - BUSY falls on the same edge DONE rises.
- Back-to-back: a new GO is accepted in the first IDLE cycle after DONE.

## Structure
- State encodings SEQ_IDLE_S..SEQ_DRAIN_S go in the shared constants.vh alongside the timer encodings.
- WDOG_MAX has a default there as SEQ_WDOG_C; the parameter overrides it.
- Single flat module, no sub-modules. The watchdog is a saturating counter inside the FSM block.
- Integration: START_TMR connects to timer.START_TMR and timer.PULSE to PULSE, sharing CLK and RST_N.

## Test plan
- Bench uses a behavioural timer with L=5.
- GO, STEPS=3: START_TMR at cycles 1, 7, 13. STEP at 7, 13, 19 with STEP_IDX 1, 2, 3. DONE at 19; BUSY low from 19. ERR=0.
- GO, STEPS=0: DONE in cycle 1, no START_TMR, BUSY never high.
- STEPS=4, ABORT in cycle 3 of the 2nd period: state DRAIN. Timer PULSE absorbed with no STEP and STEP_IDX=1, then IDLE with no DONE. Immediate GO, STEPS=1 completes in 6 cycles with exactly 1 STEP.
- Timer model muted, WDOG_MAX=20, STEPS=2: ERR rises 21 cycles after START_TMR, BUSY falls, no DONE. Next GO clears ERR.
- ABORT and PULSE coincide on the last period of STEPS=2: STEP and DONE both pulse, STEP_IDX=2, no DRAIN. Repeat on the 1st period: STEP_IDX=1, no DONE, IDLE.
- RST_N asserted mid-WAIT: all outputs zero asynchronously. The late timer PULSE after release is ignored; STEP_IDX stays 0.
